instr_fetch_unit: RTL and testbench

//  Fetch stage directly downstream of program_counter: takes the fetch address (pc_0),

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory request at a time for the address from the
// program counter and queues returned {pc, instruction} pairs for decode.
module instr_fetch_unit #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32,
   parameter int DEPTH  = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              pc_valid,
   output logic              pc_ready,
   input  logic              flush,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic [CNT_W-1:0]  fifo_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t            state;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic              push;
   logic              pop;

   // Pointers wrap at DEPTH explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign pc_ready   = (state == IDLE) && (fifo_count < CNT_W'(DEPTH)) && !flush && !rst;
   assign push       = (state == WAIT) && imem_rvalid && !flush;
   assign pop        = inst_valid && inst_ready && !flush;
   assign inst_valid = (fifo_count != '0);
   assign inst_data  = inst_valid ? inst_mem[rd_ptr] : '0;
   assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pc_valid && pc_ready) begin
                  imem_addr <= pc_in;
                  imem_req  <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (imem_gnt) begin
                  imem_req <= 1'b0;
                  state    <= flush ? DROP : WAIT;
               end else if (flush) begin
                  imem_req <= 1'b0;
                  state    <= IDLE;
               end
            end
            WAIT: begin
               // A response arriving with flush is simply discarded.
               if (imem_rvalid)
                  state <= IDLE;
               else if (flush)
                  state <= DROP;
            end
            DROP: begin
               if (imem_rvalid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= next_ptr(wr_ptr);
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)
            fifo_count <= fifo_count + CNT_W'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - CNT_W'(1);
      end
   end

   // NOTE: storage has no reset; fifo_count qualifies every entry and the head outputs are gated.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= imem_addr;
         inst_mem[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized traffic checked
// against a transaction-level model (queue of fetched pcs plus one outstanding bus request).
module tb_instr_fetch_unit;

   localparam int ADDR_W = 64;
   localparam int INST_W = 32;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] pc_in;
   logic              pc_valid;
   logic              pc_ready;
   logic              flush;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [INST_W-1:0] imem_rdata;
   logic              inst_valid;
   logic [INST_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_ready;
   logic [CNT_W-1:0]  fifo_count;

   int n_cmp = 0;
   int n_bad = 0;

   instr_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
      .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached (got hang, need $finish)");
      $fatal(1);
   end

   // Memory contents as a pure function of the address.
   function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_in = '0; pc_valid = 0; flush = 0; imem_gnt = 0;
      imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   // Best-case fetch: returns with inst_valid due in the current cycle.
   task automatic fetch(input logic [ADDR_W-1:0] a, input logic [INST_W-1:0] d);
      tick(); pc_in = a; pc_valid = 1;
      tick(); pc_valid = 0; imem_gnt = 1;
      tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = d;
      tick(); imem_rvalid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      #3;
      n_cmp++;
      if ({imem_req, inst_valid, pc_ready, fifo_count, imem_addr, inst_pc, inst_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: req=%0b valid=%0b ready=%0b cnt=%0d addr=%h pc=%h data=%h, need all 0",
                  imem_req, inst_valid, pc_ready, fifo_count, imem_addr, inst_pc, inst_data);
      end
      repeat (2) @(posedge clk);
      #1 rst = 0;
      #1;
      n_cmp++;
      if ({pc_ready, fifo_count, inst_valid} !== {1'b1, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_release: ready=%0b cnt=%0d valid=%0b, need 1/0/0", pc_ready, fifo_count, inst_valid);
      end
   endtask

   task automatic test_single_fetch();
      apply_reset();
      tick(); pc_in = 64'h40; pc_valid = 1; #1;
      n_cmp++;
      if (pc_ready !== 1'b1) begin n_bad++; $display("FAIL c0_pc_ready: got %0b need 1", pc_ready); end
      tick(); pc_valid = 0; imem_gnt = 1; #1;
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 64'h40}) begin
         n_bad++; $display("FAIL c1_request: req=%0b addr=%h need 1/40", imem_req, imem_addr);
      end
      tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; #1;
      n_cmp++;
      if ({imem_req, inst_valid} !== 2'b00) begin
         n_bad++; $display("FAIL c2_wait: req=%0b valid=%0b need 0/0", imem_req, inst_valid);
      end
      tick(); imem_rvalid = 0; #1;
      n_cmp++;
      if ({inst_valid, inst_pc, inst_data, fifo_count, pc_ready} !== {1'b1, 64'h40, 32'hDEAD_BEEF, 2'd1, 1'b1}) begin
         n_bad++;
         $display("FAIL c3_deliver: valid=%0b pc=%h data=%h cnt=%0d ready=%0b need 1/40/deadbeef/1/1",
                  inst_valid, inst_pc, inst_data, fifo_count, pc_ready);
      end
   endtask

   task automatic test_fifo_full();
      apply_reset();
      fetch(64'h0, 32'h1111_0000);
      fetch(64'h1, 32'h2222_0001);
      pc_in = 64'h2; pc_valid = 1; #1;
      n_cmp++;
      if ({fifo_count, pc_ready} !== {2'd2, 1'b0}) begin
         n_bad++; $display("FAIL full_block: cnt=%0d ready=%0b need 2/0", fifo_count, pc_ready);
      end
      pc_valid = 0;
      n_cmp++;
      if ({inst_pc, inst_data} !== {64'h0, 32'h1111_0000}) begin
         n_bad++; $display("FAIL pop_first: pc=%h data=%h need 0/11110000", inst_pc, inst_data);
      end
      inst_ready = 1;
      tick(); inst_ready = 0; #1;
      n_cmp++;
      if ({pc_ready, fifo_count, inst_pc, inst_data} !== {1'b1, 2'd1, 64'h1, 32'h2222_0001}) begin
         n_bad++;
         $display("FAIL pop_second: ready=%0b cnt=%0d pc=%h data=%h need 1/1/1/22220001",
                  pc_ready, fifo_count, inst_pc, inst_data);
      end
      inst_ready = 1;
      tick(); inst_ready = 0; #1;
      n_cmp++;
      if ({fifo_count, inst_valid} !== {2'd0, 1'b0}) begin
         n_bad++; $display("FAIL drained: cnt=%0d valid=%0b need 0/0", fifo_count, inst_valid);
      end
   endtask

   task automatic test_delayed_gnt();
      apply_reset();
      tick(); pc_in = 64'h100; pc_valid = 1;
      tick(); pc_valid = 0; pc_in = 64'hFFFF;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if ({imem_req, imem_addr} !== {1'b1, 64'h100}) begin
            n_bad++; $display("FAIL gnt_hold[%0d]: req=%0b addr=%h need 1/100", i, imem_req, imem_addr);
         end
         tick();
      end
      imem_gnt = 1;
      tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0BAD_F00D;
      tick(); imem_rvalid = 0;
      tick(); #1;
      n_cmp++;
      if ({fifo_count, inst_pc, inst_data, imem_req} !== {2'd1, 64'h100, 32'h0BAD_F00D, 1'b0}) begin
         n_bad++;
         $display("FAIL gnt_single_push: cnt=%0d pc=%h data=%h req=%0b need 1/100/0badf00d/0",
                  fifo_count, inst_pc, inst_data, imem_req);
      end
   endtask

   task automatic test_flush_in_wait();
      apply_reset();
      tick(); pc_in = 64'h60; pc_valid = 1;
      tick(); pc_valid = 0; imem_gnt = 1;
      tick(); imem_gnt = 0; flush = 1; #1;
      n_cmp++;
      if (pc_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %0b need 0", pc_ready); end
      tick(); flush = 0;
      tick(); imem_rvalid = 1; imem_rdata = 32'hCAFE_0060;
      tick(); imem_rvalid = 0; #1;
      n_cmp++;
      if ({fifo_count, inst_valid, pc_ready} !== {2'd0, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL flush_drop: cnt=%0d valid=%0b ready=%0b need 0/0/1", fifo_count, inst_valid, pc_ready);
      end
      fetch(64'h80, 32'h1234_5678); #1;
      n_cmp++;
      if ({inst_valid, inst_pc, inst_data, fifo_count} !== {1'b1, 64'h80, 32'h1234_5678, 2'd1}) begin
         n_bad++;
         $display("FAIL after_flush: valid=%0b pc=%h data=%h cnt=%0d need 1/80/12345678/1",
                  inst_valid, inst_pc, inst_data, fifo_count);
      end
   endtask

   task automatic test_flush_priority();
      apply_reset();
      fetch(64'hA0, 32'hAAAA_0000);
      fetch(64'hA4, 32'hAAAA_0004);
      inst_ready = 1; flush = 1; imem_rvalid = 1; imem_rdata = 32'h7777_7777;
      tick(); idle_inputs(); #1;
      n_cmp++;
      if ({fifo_count, inst_valid} !== {2'd0, 1'b0}) begin
         n_bad++; $display("FAIL flush_full: cnt=%0d valid=%0b need 0/0", fifo_count, inst_valid);
      end
      fetch(64'hB0, 32'hBBBB_0000);
      tick(); pc_in = 64'hB4; pc_valid = 1;
      tick(); pc_valid = 0; imem_gnt = 1;
      tick(); imem_gnt = 0; flush = 1; inst_ready = 1; imem_rvalid = 1; imem_rdata = 32'hBBBB_0004;
      tick(); idle_inputs(); #1;
      n_cmp++;
      if ({fifo_count, inst_valid, pc_ready} !== {2'd0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL flush_push_pop: cnt=%0d valid=%0b ready=%0b need 0/0/1", fifo_count, inst_valid, pc_ready);
      end
      tick(); #1;
      n_cmp++;
      if (fifo_count !== 2'd0) begin n_bad++; $display("FAIL flush_settled: cnt=%0d need 0", fifo_count); end
   endtask

   task automatic test_reset_mid_fetch();
      apply_reset();
      fetch(64'h300, 32'h3333_0300);
      tick(); pc_in = 64'h200; pc_valid = 1;
      tick(); pc_valid = 0; #1;
      n_cmp++;
      if ({imem_req, fifo_count} !== {1'b1, 2'd1}) begin
         n_bad++; $display("FAIL pre_reset: req=%0b cnt=%0d need 1/1", imem_req, fifo_count);
      end
      #1 rst = 1;
      #1;
      n_cmp++;
      if ({imem_req, inst_valid, pc_ready, fifo_count, imem_addr, inst_pc, inst_data} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: req=%0b valid=%0b ready=%0b cnt=%0d addr=%h pc=%h data=%h need all 0",
                  imem_req, inst_valid, pc_ready, fifo_count, imem_addr, inst_pc, inst_data);
      end
      tick(); tick(); rst = 0;
      imem_rvalid = 1; imem_rdata = 32'h4444_0200;
      tick(); imem_rvalid = 0; #1;
      n_cmp++;
      if ({fifo_count, inst_valid, pc_ready, imem_req} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL late_rvalid: cnt=%0d valid=%0b ready=%0b req=%0b need 0/0/1/0",
                  fifo_count, inst_valid, pc_ready, imem_req);
      end
   endtask

   // Reference: queue of delivered-to-be pcs, plus the single outstanding bus transaction
   // viewed from the memory side (waiting for grant / waiting for data / data unwanted).
   task automatic test_random();
      logic [ADDR_W-1:0] q_pc[$];
      logic [ADDR_W-1:0] m_addr;
      logic [ADDR_W-1:0] e_pc;
      logic [INST_W-1:0] e_data;
      bit m_req, m_resp, m_keep, e_ready, do_pop, do_push;
      int delivered = 0;
      apply_reset();
      m_addr = '0; m_req = 0; m_resp = 0; m_keep = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         tick();
         pc_valid    = ($urandom_range(0, 9) < 6);
         pc_in       = {$urandom, $urandom};
         flush       = ($urandom_range(0, 99) < 7);
         inst_ready  = ($urandom_range(0, 2) != 0 && cyc % 64 > 16);
         imem_gnt    = m_req && ($urandom_range(0, 2) == 0);
         imem_rvalid = m_resp ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         imem_rdata  = m_resp ? mem_word(m_addr) : $urandom;
         #1;
         e_ready = !m_req && !m_resp && (q_pc.size() < DEPTH) && !flush;
         e_pc    = (q_pc.size() != 0) ? q_pc[0] : '0;
         e_data  = (q_pc.size() != 0) ? mem_word(q_pc[0]) : '0;
         n_cmp++;
         if ({pc_ready, imem_req, imem_addr} !== {e_ready, m_req, m_addr}) begin
            n_bad++;
            $display("FAIL rnd_bus@%0d: ready=%0b req=%0b addr=%h need %0b/%0b/%h",
                     cyc, pc_ready, imem_req, imem_addr, e_ready, m_req, m_addr);
         end
         n_cmp++;
         if ({fifo_count, inst_valid, inst_pc, inst_data} !== {CNT_W'(q_pc.size()), q_pc.size() != 0, e_pc, e_data}) begin
            n_bad++;
            $display("FAIL rnd_fifo@%0d: cnt=%0d valid=%0b pc=%h data=%h need %0d/%0b/%h/%h",
                     cyc, fifo_count, inst_valid, inst_pc, inst_data, q_pc.size(), q_pc.size() != 0, e_pc, e_data);
         end
         do_pop  = (q_pc.size() != 0) && inst_ready;
         do_push = 0;
         if (m_resp && imem_rvalid) begin
            do_push = m_keep && !flush;
            m_resp  = 0;
         end else if (m_resp && flush) begin
            m_keep = 0;
         end
         if (m_req) begin
            if (imem_gnt) begin
               m_req = 0; m_resp = 1; m_keep = !flush;
            end else if (flush) begin
               m_req = 0;
            end
         end else if (e_ready && pc_valid) begin
            m_req = 1; m_addr = pc_in;
         end
         if (flush) begin
            q_pc.delete();
         end else begin
            if (do_pop) begin
               void'(q_pc.pop_front());
               delivered++;
            end
            if (do_push) q_pc.push_back(m_addr);
         end
      end
      n_cmp++;
      if (delivered < 20) begin
         n_bad++; $display("FAIL rnd_progress: delivered %0d instructions, need at least 20", delivered);
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_single_fetch();
      test_fifo_full();
      test_delayed_gnt();
      test_flush_in_wait();
      test_flush_priority();
      test_reset_mid_fetch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
